// File: rtl/adc_capture.sv
// adc_capture: record path. Deserialises the codec's left-justified ADC
// bitstream (adclrc/adcdat, sampled on bclk) into DATA_W-bit words and writes
// them to consecutive SRAM addresses starting at 0. The address and data buses
// are released (high-Z) whenever recording is off.
//
// Build option: define ADC_STEREO_EN to capture both channels. Words are then
// written L,R,L,R, and a take always begins on a left sample. Without the
// macro only the left channel is stored.
module adc_capture #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 18'h3FFFF
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              record,
    input  logic              adclrc,
    input  logic              adcdat,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we_n,
    output logic              full,
    output logic              busy
);

    localparam int               BIT_W   = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHIFT,
        WRITE,
        FULL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] shift;
    logic [BIT_W-1:0]  bitcnt;
    logic              lrc_d;
    logic              drive_en;
    logic              left_start;

`ifdef ADC_STEREO_EN
    logic              right_start;
    logic              left_done;
    logic              cur_right;
`endif

    // A left half-frame begins on the bit clock where adclrc has just risen;
    // the MSB is already on adcdat in that same cycle.
    assign left_start  = adclrc & ~lrc_d;
`ifdef ADC_STEREO_EN
    assign right_start = ~adclrc & lrc_d;
`endif

    // Buses float unless recording; data is only driven while strobing.
    assign addr  = drive_en ? addr_q : {ADDR_W{1'bz}};
    assign wdata = (!we_n)  ? shift  : {DATA_W{1'bz}};

    // Capture state machine: arm on a frame start, shift in one word, strobe it
    // into SRAM, then advance the address until the last location is written.
    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            shift    <= '0;
            bitcnt   <= '0;
            we_n     <= 1'b1;
            full     <= 1'b0;
            busy     <= 1'b0;
            lrc_d    <= 1'b0;
            drive_en <= 1'b0;
`ifdef ADC_STEREO_EN
            left_done <= 1'b0;
            cur_right <= 1'b0;
`endif
        end else begin
            lrc_d    <= adclrc;
            drive_en <= record;
            if (!record) begin
                state  <= IDLE;
                bitcnt <= '0;
                we_n   <= 1'b1;
                full   <= 1'b0;
                busy   <= 1'b0;
`ifdef ADC_STEREO_EN
                left_done <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state  <= ARM;
                        addr_q <= '0;
                        we_n   <= 1'b1;
                        busy   <= 1'b0;
                    end
                    ARM: begin
                        if (left_start) begin
                            state             <= SHIFT;
                            shift[DATA_W-1]   <= adcdat;
                            bitcnt            <= BIT_W'(1);
                            busy              <= 1'b1;
`ifdef ADC_STEREO_EN
                            cur_right         <= 1'b0;
                        end else if (right_start && left_done) begin
                            state             <= SHIFT;
                            shift[DATA_W-1]   <= adcdat;
                            bitcnt            <= BIT_W'(1);
                            busy              <= 1'b1;
                            cur_right         <= 1'b1;
`endif
                        end
                    end
                    SHIFT: begin
                        shift[TOP_BIT - bitcnt] <= adcdat;
                        bitcnt                  <= bitcnt + 1'b1;
                        if (bitcnt == TOP_BIT) begin
                            state <= WRITE;
                            we_n  <= 1'b0;
                        end
                    end
                    WRITE: begin
                        we_n <= 1'b1;
                        busy <= 1'b0;
`ifdef ADC_STEREO_EN
                        left_done <= ~cur_right;
`endif
                        if (addr_q == LAST_ADDR) begin
                            full  <= 1'b1;
                            state <= FULL;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            state  <= ARM;
                        end
                    end
                    FULL: begin
                        we_n <= 1'b1;
                        full <= 1'b1;
                        busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        we_n  <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: self-checking bench for adc_capture with a 4-word memory.
// Frames are table-driven; expected SRAM writes go into a scoreboard queue and
// are compared whenever the DUT strobes we_n. Released buses read as all-ones
// through pulled-up nets.
module tb_adc_capture;

    localparam int               DATA_W = 16;
    localparam int               ADDR_W = 18;
    localparam logic [ADDR_W-1:0] LAST  = 18'd3;

    logic bclk = 1'b0;
    logic rst_n;
    logic record;
    logic adclrc;
    logic adcdat;
    tri1 [ADDR_W-1:0] addr;
    tri1 [DATA_W-1:0] wdata;
    logic we_n;
    logic full;
    logic busy;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] next_addr = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        int                glitch;
        bit                exp_l;
        bit                exp_r;
        bit                exp_full;
    } vec_t;
    vec_t vecs[5];

    adc_capture #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST)
    ) dut (
        .bclk  (bclk),
        .rst_n (rst_n),
        .record(record),
        .adclrc(adclrc),
        .adcdat(adcdat),
        .addr  (addr),
        .wdata (wdata),
        .we_n  (we_n),
        .full  (full),
        .busy  (busy)
    );

    always #5 bclk = ~bclk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [DATA_W-1:0] data);
        wr_t w;
        w.addr = next_addr;
        w.data = data;
        sb.push_back(w);
        next_addr = next_addr + 1'b1;
    endtask

    // One 40-bit frame: 20 bclks left (adclrc=1), then 20 bclks right.
    // glitch >= 0 pulls adclrc low for one bit inside the left half.
    task automatic applyStimulus(input logic [DATA_W-1:0] left,
                                 input logic [DATA_W-1:0] right,
                                 input int glitch, input bit exp_l,
                                 input bit exp_r);
        int strobe_i;
        strobe_i = -1;
        if (exp_l) expectWrite(left);
        if (exp_r) expectWrite(right);
        for (int i = 0; i < 20; i++) begin
            @(negedge bclk);
            adclrc = (i == glitch) ? 1'b0 : 1'b1;
            adcdat = (i < DATA_W) ? left[DATA_W-1-i] : 1'b0;
            if (we_n === 1'b0 && strobe_i < 0) strobe_i = i;
        end
        if (exp_l) checkOutput("strobe_latency", strobe_i, 16);
        for (int i = 0; i < 20; i++) begin
            @(negedge bclk);
            adclrc = 1'b0;
            adcdat = (i < DATA_W) ? right[DATA_W-1-i] : 1'b0;
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected write.
    always @(negedge bclk) begin
        wr_t e;
        if (rst_n === 1'b1 && we_n === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                         addr, wdata);
            end else begin
                e = sb.pop_front();
                checkOutput("write_addr", 32'(addr), 32'(e.addr));
                checkOutput("write_data", 32'(wdata), 32'(e.data));
            end
        end
    end

    // Main sequence: reset, a full take, an aborted frame, then a fresh take.
    initial begin
`ifdef ADC_STEREO_EN
        vecs[0] = '{16'hA5C3, 16'h0F0F, -1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'hFEDC, -1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{16'h8001, 16'h7FFE,  6, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h00FF, 16'hC33C, -1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h5555, 16'hAAAA, -1, 1'b0, 1'b0, 1'b1};
`else
        vecs[0] = '{16'hA5C3, 16'h0F0F, -1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 16'hFEDC, -1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8001, 16'h7FFE,  6, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h00FF, 16'hC33C, -1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h5555, 16'hAAAA, -1, 1'b0, 1'b0, 1'b1};
`endif
        rst_n  = 1'b0;
        record = 1'b1;
        adclrc = 1'b0;
        adcdat = 1'b0;
        repeat (2) @(negedge bclk);
        checkOutput("reset_we_n", 32'(we_n), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge bclk);

        next_addr = '0;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].left, vecs[v].right, vecs[v].glitch,
                          vecs[v].exp_l, vecs[v].exp_r);
            checkOutput($sformatf("full_row%0d", v), 32'(full), 32'(vecs[v].exp_full));
        end
        checkOutput("full_addr_hold", 32'(addr), 32'(LAST));
        checkOutput("full_we_n", 32'(we_n), 32'd1);

        // Leave FULL, re-arm, then abort a frame after 8 bits.
        record = 1'b0;
        repeat (2) @(negedge bclk);
        record = 1'b1;
        repeat (2) @(negedge bclk);
        for (int i = 0; i < 8; i++) begin
            @(negedge bclk);
            adclrc = 1'b1;
            adcdat = i[0];
        end
        checkOutput("busy_shift", 32'(busy), 32'd1);
        @(negedge bclk);
        record = 1'b0;
        adcdat = 1'b1;
        @(negedge bclk);
        checkOutput("abort_we_n", 32'(we_n), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_full", 32'(full), 32'd0);
        checkOutput("abort_addr_z", 32'(addr), 32'h3FFFF);
        checkOutput("abort_wdata_z", 32'(wdata), 32'hFFFF);
        for (int i = 10; i < 20; i++) begin
            @(negedge bclk);
            adcdat = i[0];
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge bclk);
            adclrc = 1'b0;
            adcdat = i[1];
        end

        // Fresh take must restart at address 0.
        record = 1'b1;
        repeat (2) @(negedge bclk);
        next_addr = '0;
`ifdef ADC_STEREO_EN
        applyStimulus(16'h1234, 16'hFEDC, -1, 1'b1, 1'b1);
        applyStimulus(16'h3C5A, 16'h0001, -1, 1'b1, 1'b1);
`else
        applyStimulus(16'h1234, 16'hFEDC, -1, 1'b1, 1'b0);
        applyStimulus(16'h3C5A, 16'h0001, -1, 1'b1, 1'b0);
`endif
        checkOutput("take2_full", 32'(full), 32'd0);

        repeat (30) @(negedge bclk);
        checkOutput("pending_writes", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
